// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD card access arbiter.
//   state_e        : sequencer states (ABORT only exists with SD_ARB_TIMEOUT_EN)
//   SECTOR_BYTES   : bytes per SD sector
//   SECTOR_ADDR_W  : width of a sector address
//   OP_READ/WRITE  : encoding of req_op / sd_op_code
package sd_arb_pkg;
  localparam int   SECTOR_BYTES  = 512;
  localparam int   SECTOR_ADDR_W = 26;
  localparam logic OP_READ       = 1'b0;
  localparam logic OP_WRITE      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_XFER,
    ST_DONE
`ifdef SD_ARB_TIMEOUT_EN
    , ST_ABORT
`endif
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_valid  : per-requester request
//   last_grant : index of the most recently served requester
//   grant      : one-hot pick, first valid requester after last_grant (wrapping)
//   grant_idx  : binary index of the pick
//   any_valid  : at least one requester is valid
module rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Walk from last_grant+1 around the ring; the first hit wins.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of one SD sector
// controller. Grants one requester, latches its op/sector, pulses sd_execute
// once, then steers the controller's per-byte handshake to the owner and
// reports done/err.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/op/sector/wdata  : per-requester request (sector 26b, wdata 8b each)
//   req_ready                  : one-cycle grant pulse
//   rd_data, rd_valid          : read byte and per-owner strobe
//   wr_take                    : per-owner "byte consumed" strobe
//   done, err                  : end-of-transaction pulse, failure flag
//   sd_*                       : controller command outputs / status inputs
// Build option: SD_ARB_TIMEOUT_EN adds a stall counter and the ABORT state.
module sd_access_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_op,
  input  logic [N_REQ*SECTOR_ADDR_W-1:0]   req_sector,
  input  logic [N_REQ*8-1:0]               req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [7:0]                       rd_data,
  output logic [N_REQ-1:0]                 rd_valid,
  output logic [N_REQ-1:0]                 wr_take,
  output logic [N_REQ-1:0]                 done,
  output logic [N_REQ-1:0]                 err,
  output logic                             sd_op_code,
  output logic [SECTOR_ADDR_W-1:0]         sd_sector_address,
  output logic [7:0]                       sd_outgoing_byte,
  output logic                             sd_execute,
  input  logic [7:0]                       sd_incoming_byte,
  input  logic                             sd_finished_byte,
  input  logic                             sd_finished_sector,
  input  logic                             sd_busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     owner_q, last_grant_q, grant_idx;
  logic [N_REQ-1:0]                     grant, owner_oh;
  logic                                 any_valid;
  logic [9:0]                           byte_cnt;
  logic                                 overrun;
  logic                                 fb_q, fb_q2, fs_q, fs_q2;
  logic                                 byte_ev, sect_ev;
  logic [N_REQ-1:0][SECTOR_ADDR_W-1:0]  sector_arr;
  logic [N_REQ-1:0][7:0]                wdata_arr;

  assign sector_arr = req_sector;
  assign wdata_arr  = req_wdata;
  assign owner_oh   = N_REQ'(1) << owner_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  // The controller changes its strobes on the falling edge: register once,
  // then detect the rising edge so each strobe counts exactly one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q  <= 1'b0;
      fb_q2 <= 1'b0;
      fs_q  <= 1'b0;
      fs_q2 <= 1'b0;
    end else begin
      fb_q  <= sd_finished_byte;
      fb_q2 <= fb_q;
      fs_q  <= sd_finished_sector;
      fs_q2 <= fs_q;
    end
  end
  assign byte_ev = fb_q & ~fb_q2;
  assign sect_ev = fs_q & ~fs_q2;

  // Write data goes straight from the owner to the controller while it owns it.
  assign sd_outgoing_byte = (state_q == ST_WAIT_BUSY || state_q == ST_XFER)
                            ? wdata_arr[owner_q] : 8'h00;

`ifdef SD_ARB_TIMEOUT_EN
  // The ISSUE and ABORT cycles count toward the limit, so done lands exactly
  // TIMEOUT_CYCLES after the grant pulse.
  localparam logic [21:0] STALL_LIM = 22'(TIMEOUT_CYCLES - 3);
  logic [21:0] stall_cnt;
  logic        stall_hit;

  assign stall_hit = (stall_cnt >= STALL_LIM) && !byte_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state_q == ST_ISSUE || byte_ev)
      stall_cnt <= '0;
    else if (state_q == ST_WAIT_BUSY || state_q == ST_XFER)
      stall_cnt <= stall_cnt + 22'd1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!sd_busy && any_valid) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (sd_busy) state_d = ST_XFER;
      ST_XFER:      if (sect_ev) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
`ifdef SD_ARB_TIMEOUT_EN
      ST_ABORT:     state_d = ST_IDLE;
`endif
      default:      state_d = ST_IDLE;
    endcase
`ifdef SD_ARB_TIMEOUT_EN
    if ((state_q == ST_WAIT_BUSY || state_q == ST_XFER) && stall_hit &&
        state_d != ST_DONE)
      state_d = ST_ABORT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q           <= '0;
      last_grant_q      <= IDX_W'(N_REQ - 1);
      req_ready         <= '0;
      rd_valid          <= '0;
      wr_take           <= '0;
      done              <= '0;
      err               <= '0;
      rd_data           <= 8'h00;
      sd_op_code        <= OP_READ;
      sd_sector_address <= '0;
      sd_execute        <= 1'b0;
      byte_cnt          <= '0;
      overrun           <= 1'b0;
    end else begin
      req_ready  <= '0;
      rd_valid   <= '0;
      wr_take    <= '0;
      done       <= '0;
      err        <= '0;
      sd_execute <= 1'b0;
      case (state_q)
        ST_IDLE: if (state_d == ST_ISSUE) begin
          req_ready         <= grant;
          owner_q           <= grant_idx;
          sd_op_code        <= req_op[grant_idx];
          sd_sector_address <= sector_arr[grant_idx];
        end
        ST_ISSUE: begin
          sd_execute <= 1'b1;
          byte_cnt   <= '0;
          overrun    <= 1'b0;
        end
        ST_XFER: if (byte_ev) begin
          if (byte_cnt < 10'(SECTOR_BYTES)) begin
            if (sd_op_code == OP_WRITE) begin
              wr_take <= owner_oh;
            end else begin
              rd_valid <= owner_oh;
              rd_data  <= sd_incoming_byte;
            end
            byte_cnt <= byte_cnt + 10'd1;
          end else begin
            overrun <= 1'b1;
          end
        end
        ST_DONE: begin
          done         <= owner_oh;
          err          <= (byte_cnt != 10'(SECTOR_BYTES) || overrun) ? owner_oh : '0;
          last_grant_q <= owner_q;
        end
`ifdef SD_ARB_TIMEOUT_EN
        ST_ABORT: begin
          done         <= owner_oh;
          err          <= owner_oh;
          last_grant_q <= owner_q;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sd_access_arbiter.md
# sd_access_arbiter

Round-robin arbiter and transaction sequencer that shares one SD card sector controller among `N_REQ` requesters (e.g. file-system engine, data logger). It grants one requester at a time, latches its operation and sector, and issues a single execute pulse to the controller. It then steers the controller's per-byte handshake to the owner and reports completion, short/overrun sectors and, optionally, stalls. It sits between the requesters and the sector controller and is the only block allowed to drive the controller's command inputs.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 2_000_000: stall limit in `clk` cycles; used only with `SD_ARB_TIMEOUT_EN`.
- `clk` in 1: master clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i wants a sector op.
- `req_op` in N_REQ: per requester; 0 = READ, 1 = WRITE.
- `req_sector` in N_REQ*26: per-requester sector address; requester i uses bits [26i+25:26i].
- `req_wdata` in N_REQ*8: per-requester write byte, presented before each `wr_take`.
- `req_ready` out N_REQ: one-cycle grant pulse; the request is latched in that cycle.
- `rd_data` out 8: read byte, valid while `rd_valid` is high.
- `rd_valid` out N_REQ: one-cycle pulse to the owner for each read byte.
- `wr_take` out N_REQ: one-cycle pulse to the owner; the current byte has been consumed and the owner must present the next byte by the next cycle.
- `done` out N_REQ: one-cycle pulse to the owner at the end of its transaction.
- `err` out N_REQ: pulses together with `done` when the transaction failed.
- `sd_op_code`, `sd_sector_address[25:0]`, `sd_outgoing_byte[7:0]`, `sd_execute` out: drive the controller.
- `sd_incoming_byte[7:0]`, `sd_finished_byte`, `sd_finished_sector`, `sd_busy` in: controller status inputs.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, XFER, DONE, plus ABORT when the macro is defined.
- IDLE: if `sd_busy`=0 and any `req_valid`, `rr_arbiter` picks the first valid requester after `last_grant`, wrapping at N_REQ.
  - Latch owner, `req_op` and `req_sector` into `sd_op_code`/`sd_sector_address`.
  - Pulse `req_ready[owner]` and go to ISSUE.
  - A requester dropping `req_valid` before it is granted gets no grant.
- ISSUE: `sd_execute`=1 for exactly one cycle; clear `byte_cnt` and `overrun`; go to WAIT_BUSY.
- WAIT_BUSY: go to XFER when `sd_busy`=1.
- XFER: the controller updates on the negedge, so `sd_finished_byte` and `sd_finished_sector` are registered once and rising-edge detected. Each byte event does the following:
  - If `byte_cnt` < 512: READ pulses `rd_valid[owner]` with `rd_data` = `sd_incoming_byte`; WRITE pulses `wr_take[owner]`. Then `byte_cnt`++.
  - If `byte_cnt` = 512: the event is dropped (no pulse) and `overrun` is set.
  - `sd_outgoing_byte` is a combinational mux of `req_wdata` for the owner.
  - A sector event goes to DONE. If a byte event and a sector event occur in the same cycle, the byte is handled first, then the transition happens.
- DONE: pulse `done[owner]`. Also pulse `err[owner]` if `byte_cnt` ≠ 512 or `overrun`. Set `last_grant` = owner and return to IDLE.
- Requester inputs other than `req_wdata` are ignored after grant.

## Timing
- Reset values: all outputs 0; `sd_sector_address`=0; `last_grant`=N_REQ-1, so requester 0 wins first; state IDLE.
- Latency:
  - `req_valid` to `req_ready`: 1 cycle when `sd_busy`=0.
  - `req_ready` to `sd_execute`: 1 cycle.
  - Controller byte edge to `rd_valid`/`wr_take`: 2 cycles.
  - Sector edge to `done`: 3 cycles.
- Back-to-back transactions: the next grant happens no earlier than the cycle after DONE, and only once `sd_busy`=0.
- Reset mid-transaction: outputs return to reset values immediately. The controller cannot be cancelled, so IDLE waits for `sd_busy`=0 before the next grant.
- `byte_cnt` is 10 bits wide and saturates at 512.

## Configuration
- `SD_ARB_TIMEOUT_EN` defined:
  - A 22-bit stall counter runs in WAIT_BUSY and XFER and clears on ISSUE and on every byte event.
  - When it reaches `TIMEOUT_CYCLES`, go to ABORT: pulse `done[owner]` and `err[owner]`, then IDLE.
- `SD_ARB_TIMEOUT_EN` undefined: no counter and no ABORT state. `err` comes only from short or overrun counts, and a hung controller holds the arbiter in WAIT_BUSY or XFER.

## Structure
- Package `sd_arb_pkg` holds:
  - the state enum;
  - `SECTOR_BYTES`=512;
  - `SECTOR_ADDR_W`=26;
  - `OP_READ`/`OP_WRITE`.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from `req_valid` and `last_grant`, N_REQ-parameterised.

## Test plan
- After reset, `req_valid`=2'b11 → `req_ready`=2'b01. After requester 0's `done`, with `req_valid`=2'b10 → `req_ready`=2'b10.
- Requester 1 READ of sector 26'h12345; model returns 512 bytes 0..255,0..255 → `sd_sector_address`=26'h12345, `sd_op_code`=0, 512 `rd_valid[1]` pulses with matching `rd_data`, then `done[1]`=1 and `err[1]`=0.
- Requester 0 WRITE of sector 7; requester 0 supplies byte = count on each `wr_take` → model captures 0x00..0xFF twice, then `done[0]`; `req_ready`, `sd_execute` and `done` are each a single one-cycle pulse.
- Model sends 511 bytes, then a sector event in the same cycle as the last byte edge → 511 pulses, then `done`=1 and `err`=1. Same with 513 bytes → 512 pulses and `err`=1.
- `sd_busy` held high at request time → no grant. Assert `rst_n`=0 mid-XFER → all outputs go to 0 within the same cycle, and no grant is issued until `sd_busy`=0.
- With `SD_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, the model never raises `sd_busy` → `done`=`err`=1 exactly 100 cycles after ISSUE.
